// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of PR numbers, alloc at head, free at tail, rewind at head.
// Zero-latency: PR_new is combinational from head; illegal alloc-while-empty and free-while-full are dropped.
module free_list #(
    parameter int PR_W  = 6,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    output logic [PR_W-1:0]  PR_new,
    output logic             empty,
    input  logic             free_en,
    input  logic [PR_W-1:0]  PR_old_rd,
    input  logic             recover,
    input  logic             RegDest_ROB,
    output logic [PTR_W:0]   free_cnt
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PR_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             alloc_ok;
    logic             free_ok;
    logic             rewind_ok;

    // Dispatch is frozen during recovery, so recover masks alloc.
    assign alloc_ok  = alloc && !recover && (count != '0);
    assign rewind_ok = recover && RegDest_ROB && (count != FULL);
    assign free_ok   = free_en && (count != FULL);

    assign PR_new   = mem[head];
    assign empty    = (count == '0);
    assign free_cnt = count;

    always_comb begin
        count_nxt = count;
        if (free_ok)   count_nxt = count_nxt + (PTR_W+1)'(1);
        if (rewind_ok) count_nxt = count_nxt + (PTR_W+1)'(1);
        if (alloc_ok)  count_nxt = count_nxt - (PTR_W+1)'(1);
    end

    // Registers above the architectural set start out free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PR_W'(DEPTH + i);
            end
        end else if (free_ok) begin
            mem[tail] <= PR_old_rd;
        end
    end

    // Rewind leaves the entry intact: the flushed register is still in the slot behind head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= FULL;
        end else begin
            if (alloc_ok) begin
                head <= head + PTR_W'(1);
            end else if (rewind_ok) begin
                head <= head - PTR_W'(1);
            end
            if (free_ok) begin
                tail <= tail + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic against a queue model.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc = 1'b0;
    logic [5:0] PR_new;
    logic       empty;
    logic       free_en = 1'b0;
    logic [5:0] PR_old_rd = '0;
    logic       recover = 1'b0;
    logic       RegDest_ROB = 1'b0;
    logic [5:0] free_cnt;

    int checks = 0;
    int passed = 0;

    // Model: q holds free registers in hand-out order; hist holds registers allocated
    // whose slot behind head has not yet been overwritten by a free (newest at back).
    logic [5:0] q[$];
    logic [5:0] hist[$];

    free_list #(.PR_W(6), .DEPTH(32), .PTR_W(5)) dut (
        .clk(clk), .rst(rst), .alloc(alloc), .PR_new(PR_new), .empty(empty),
        .free_en(free_en), .PR_old_rd(PR_old_rd), .recover(recover),
        .RegDest_ROB(RegDest_ROB), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        hist.delete();
        for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock: drive inputs, update the model at the edge, release inputs just after.
    task automatic cyc(input logic a, input logic f, input logic [5:0] pr,
                       input logic r, input logic rd);
        int cnt0;
        alloc = a; free_en = f; PR_old_rd = pr; recover = r; RegDest_ROB = rd;
        @(posedge clk);
        cnt0 = q.size();
        if (r) begin
            if (rd && cnt0 != 32 && hist.size() > 0) q.push_front(hist.pop_back());
        end else if (a && cnt0 > 0) begin
            hist.push_back(q.pop_front());
        end
        if (f && cnt0 != 32) q.push_back(pr);
        while (hist.size() > 32 - q.size()) void'(hist.pop_front());
        #1;
        alloc = 1'b0; free_en = 1'b0; recover = 1'b0; RegDest_ROB = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (PR_new !== 6'h20 || free_cnt !== 6'd32 || empty !== 1'b0)
            $display("FAIL reset_state: PR_new=%h free_cnt=%0d empty=%b, want 20/32/0", PR_new, free_cnt, empty);
        else passed++;
    endtask

    task automatic test_alloc_seq();
        logic [5:0] exp_seq[3] = '{6'h20, 6'h21, 6'h22};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (PR_new !== exp_seq[i])
                $display("FAIL alloc_seq[%0d]: PR_new=%h want %h", i, PR_new, exp_seq[i]);
            else passed++;
            cyc(1, 0, 0, 0, 0);
        end
        checks++;
        if (PR_new !== 6'h23 || free_cnt !== 6'd29)
            $display("FAIL alloc_after3: PR_new=%h free_cnt=%0d want 23/29", PR_new, free_cnt);
        else passed++;
    endtask

    task automatic test_recover();
        cyc(0, 0, 0, 1, 1);
        checks++;
        if (PR_new !== 6'h22 || free_cnt !== 6'd30)
            $display("FAIL rewind: PR_new=%h free_cnt=%0d want 22/30", PR_new, free_cnt);
        else passed++;
        cyc(0, 0, 0, 1, 0);
        checks++;
        if (PR_new !== 6'h22 || free_cnt !== 6'd30)
            $display("FAIL recover_nodest: PR_new=%h free_cnt=%0d want 22/30", PR_new, free_cnt);
        else passed++;
        cyc(1, 0, 0, 1, 0);
        checks++;
        if (PR_new !== 6'h22 || free_cnt !== 6'd30)
            $display("FAIL recover_alloc: PR_new=%h free_cnt=%0d want 22/30", PR_new, free_cnt);
        else passed++;
        cyc(0, 0, 0, 1, 1);
        checks++;
        if (PR_new !== 6'h21 || free_cnt !== 6'd31)
            $display("FAIL rewind2: PR_new=%h free_cnt=%0d want 21/31", PR_new, free_cnt);
        else passed++;
    endtask

    task automatic test_empty();
        do_reset();
        repeat (32) cyc(1, 0, 0, 0, 0);
        checks++;
        if (empty !== 1'b1 || free_cnt !== 6'd0)
            $display("FAIL empty_after32: empty=%b free_cnt=%0d want 1/0", empty, free_cnt);
        else passed++;
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (empty !== 1'b1 || free_cnt !== 6'd0)
            $display("FAIL alloc_when_empty: empty=%b free_cnt=%0d want 1/0", empty, free_cnt);
        else passed++;
        cyc(1, 1, 6'h03, 0, 0);
        checks++;
        if (empty !== 1'b0 || PR_new !== 6'h03 || free_cnt !== 6'd1)
            $display("FAIL free_when_empty: empty=%b PR_new=%h free_cnt=%0d want 0/03/1", empty, PR_new, free_cnt);
        else passed++;
        do_reset();
        cyc(0, 1, 6'h05, 0, 0);
        checks++;
        if (PR_new !== 6'h20 || free_cnt !== 6'd32)
            $display("FAIL free_when_full: PR_new=%h free_cnt=%0d want 20/32", PR_new, free_cnt);
        else passed++;
    endtask

    task automatic test_alloc_free();
        do_reset();
        repeat (22) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 6'h06, 0, 0);
        checks++;
        if (free_cnt !== 6'd10 || PR_new !== 6'h37)
            $display("FAIL alloc_free_same: free_cnt=%0d PR_new=%h want 10/37", free_cnt, PR_new);
        else passed++;
        repeat (9) cyc(1, 0, 0, 0, 0);
        checks++;
        if (PR_new !== 6'h06 || free_cnt !== 6'd1)
            $display("FAIL freed_order: PR_new=%h free_cnt=%0d want 06/1", PR_new, free_cnt);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [5:0] exp_pr;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            exp_pr = (i < 32) ? 6'(32 + i) : 6'(i - 32);
            if (PR_new !== exp_pr) bad++;
            cyc(1, 0, 0, 0, 0);
            cyc(0, 1, 6'(i), 0, 0);
            if (free_cnt > 6'd32) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL wrap_order: %0d errors, want 0", bad);
        else passed++;
        checks++;
        if (PR_new !== 6'h08 || free_cnt !== 6'd32)
            $display("FAIL wrap_end: PR_new=%h free_cnt=%0d want 08/32", PR_new, free_cnt);
        else passed++;
    endtask

    task automatic test_random();
        logic a, f, r, rd;
        logic [5:0] pr;
        int errs = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            a  = ($urandom_range(0, 99) < 55);
            f  = ($urandom_range(0, 99) < 45);
            r  = ($urandom_range(0, 99) < 12);
            rd = $urandom_range(0, 1);
            pr = 6'($urandom_range(0, 63));
            // Rewind is only meaningful when an allocation is still recorded behind head.
            if (r && rd && (hist.size() == 0 || (f && q.size() > 30))) rd = 1'b0;
            cyc(a, f, pr, r, rd);
            if (empty !== (q.size() == 0) || free_cnt !== 6'(q.size()) ||
                (q.size() > 0 && PR_new !== q[0])) begin
                if (errs < 5)
                    $display("FAIL random[%0d]: PR_new=%h empty=%b free_cnt=%0d want %h/%b/%0d", n,
                             PR_new, empty, free_cnt, (q.size() > 0) ? q[0] : 6'h0, q.size() == 0, q.size());
                errs++;
            end
        end
        checks++;
        if (errs == 0) passed++;
    endtask

    task automatic test_async_reset();
        repeat (5) cyc(1, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (PR_new !== 6'h20 || free_cnt !== 6'd32 || empty !== 1'b0)
            $display("FAIL async_reset: PR_new=%h free_cnt=%0d empty=%b want 20/32/0", PR_new, free_cnt, empty);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (PR_new !== 6'h21 || free_cnt !== 6'd31)
            $display("FAIL after_async_reset: PR_new=%h free_cnt=%0d want 21/31", PR_new, free_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alloc_seq();
        test_recover();
        test_empty();
        test_alloc_free();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
